bcd_conv_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one binary-to-decimal converter (8-bit binary in, three 8-bit decimal digits out) among NUM_REQ requesters, e.g. cumulative-sum channels feeding the display path.
- Accepts one request at a time and drives the converter operand from a register.
- Waits CONV_LAT cycles, samples the digits, then returns them with the requester ID over a valid/ready response channel.

---
 rtl/bcd_conv_arbiter.sv | 150 +++++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_arbiter.sv
// Round-robin sequencer sharing one binary-to-decimal converter among NUM_REQ requesters.
// Optional converter self-check is built when BCD_CONV_CHECK_EN is defined; otherwise err_o is 0.
module bcd_conv_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned CONV_LAT = 1,
    parameter int unsigned ID_W     = $clog2(NUM_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ*8-1:0] bin_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic [7:0]           conv_bin_o,
    input  logic [7:0]           conv_dec_i [3],
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [ID_W-1:0]      rsp_id_o,
    output logic [7:0]           rsp_dec_o [3],
    output logic                 err_o
);

    localparam int unsigned CntW = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

    typedef enum logic [1:0] {StIdle, StConv, StResp} state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [ID_W-1:0]     r_last;
    logic [ID_W-1:0]     r_id;
    logic [CntW-1:0]     r_cnt;

    logic                w_arb;
    logic                w_sample;
    logic [NUM_REQ-1:0]  w_rot;
    logic [ID_W-1:0]     w_off;
    logic                w_found;
    logic [ID_W-1:0]     w_win;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [7:0]          w_bin;

    // Rotate requests so bit 0 is the requester just after the last winner.
    assign w_rot = NUM_REQ'({req_i, req_i} >> (int'(r_last) + 1));

    always_comb begin
        w_off   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = ID_W'(i);
            end
        end
        w_win = ID_W'((int'(r_last) + 1 + int'(w_off)) % NUM_REQ);
        w_gnt = '0;
        w_gnt[w_win] = 1'b1;
        w_bin = bin_i[{w_win, 3'b000} +: 8];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_arb       = 1'b0;
        w_sample    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (|req_i) begin
                    w_arb       = 1'b1;
                    w_state_nxt = StConv;
                end
            end
            StConv: begin
                if (r_cnt == '0) begin
                    w_sample    = 1'b1;
                    w_state_nxt = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    if (|req_i) begin
                        w_arb       = 1'b1;
                        w_state_nxt = StConv;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_o       <= '0;
            conv_bin_o  <= '0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= '0;
            rsp_dec_o   <= '{default: '0};
            r_id        <= '0;
            r_last      <= ID_W'(NUM_REQ - 1);
            r_cnt       <= '0;
        end else begin
            gnt_o <= w_arb ? w_gnt : '0;
            if (w_arb) begin
                conv_bin_o <= w_bin;
                r_id       <= w_win;
                r_last     <= w_win;
                r_cnt      <= CntW'(CONV_LAT - 1);
            end else if (r_state == StConv && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_sample) begin
                rsp_valid_o <= 1'b1;
                rsp_id_o    <= r_id;
                rsp_dec_o   <= conv_dec_i;
            end else if (r_state == StResp && rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
            end
        end
    end

`ifdef BCD_CONV_CHECK_EN
    logic [15:0] w_sum;
    logic        w_bad;

    always_comb begin
        w_sum = 16'(conv_dec_i[2]) * 16'd100 + 16'(conv_dec_i[1]) * 16'd10
              + 16'(conv_dec_i[0]);
        w_bad = (conv_dec_i[2] > 8'd2) || (conv_dec_i[1] > 8'd9) || (conv_dec_i[0] > 8'd9)
             || (w_sum != 16'(conv_bin_o));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (w_sample && w_bad) begin
            err_o <= 1'b1;
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed and randomized bench for bcd_conv_arbiter; a second instance covers CONV_LAT=3.
module tb_bcd_conv_arbiter;

    localparam int N = 4;
`ifdef BCD_CONV_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance 1: CONV_LAT = 1
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*8-1:0] bin;
    logic [N-1:0]   gnt;
    logic [7:0]     conv_bin;
    logic [7:0]     conv_dec [3];
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [7:0]     rsp_dec [3];
    logic           err;
    logic           corrupt;

    // Instance 2: CONV_LAT = 3
    logic           rst2_n;
    logic [N-1:0]   req2;
    logic [N*8-1:0] bin2;
    logic [N-1:0]   gnt2;
    logic [7:0]     conv_bin2;
    logic [7:0]     conv_dec2 [3];
    logic           rsp_valid2;
    logic           rsp_ready2;
    logic [1:0]     rsp_id2;
    logic [7:0]     rsp_dec2 [3];
    logic           err2;

    function automatic logic [7:0] dgt(input logic [7:0] v, input int k);
        if (k == 2) return v / 8'd100;
        if (k == 1) return (v / 8'd10) % 8'd10;
        return v % 8'd10;
    endfunction

    always_comb begin
        for (int k = 0; k < 3; k++) conv_dec[k] = dgt(conv_bin, k);
        if (corrupt && conv_bin == 8'd58) conv_dec[1] = 8'd6;
        for (int k = 0; k < 3; k++) conv_dec2[k] = dgt(conv_bin2, k);
    end

    bcd_conv_arbiter #(.NUM_REQ(N), .CONV_LAT(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .bin_i(bin), .gnt_o(gnt),
        .conv_bin_o(conv_bin), .conv_dec_i(conv_dec), .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id), .rsp_dec_o(rsp_dec), .err_o(err)
    );

    bcd_conv_arbiter #(.NUM_REQ(N), .CONV_LAT(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst2_n), .req_i(req2), .bin_i(bin2), .gnt_o(gnt2),
        .conv_bin_o(conv_bin2), .conv_dec_i(conv_dec2), .rsp_valid_o(rsp_valid2),
        .rsp_ready_i(rsp_ready2), .rsp_id_o(rsp_id2), .rsp_dec_o(rsp_dec2), .err_o(err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input int id, input logic [7:0] v);
        chk({tag, "_valid"}, 32'(rsp_valid), 1);
        chk({tag, "_id"}, 32'(rsp_id), id);
        for (int k = 0; k < 3; k++) chk({tag, "_dec"}, 32'(rsp_dec[k]), 32'(dgt(v, k)));
    endtask

    task automatic reset1();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        rsp_ready = 1'b1;
        corrupt = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {int id; logic [7:0] v;} exp_t;
    exp_t q[$];

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t;
        int model_last;
        int w;
        bit found;
        rst_n = 1'b0; req = '0; bin = '0; rsp_ready = 1'b1; corrupt = 1'b0;
        rst2_n = 1'b0; req2 = '0; bin2 = '0; rsp_ready2 = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_conv_bin", 32'(conv_bin), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_id", 32'(rsp_id), 0);
        for (int k = 0; k < 3; k++) chk("rst_dec", 32'(rsp_dec[k]), 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1'b1;

        // Single request, operand 237
        bin[7:0] = 8'd237; req = 4'b0001;
        @(negedge clk);
        chk("single_gnt", 32'(gnt), 1);
        chk("single_conv_bin", 32'(conv_bin), 237);
        chk("single_valid_early", 32'(rsp_valid), 0);
        req = '0;
        @(negedge clk);
        chk("single_gnt_pulse", 32'(gnt), 0);
        chk_rsp("single_rsp", 0, 8'd237);
        @(negedge clk);
        chk("single_valid_clr", 32'(rsp_valid), 0);

        // Four simultaneous requests, back-to-back
        reset1();
        bin = {8'd255, 8'd100, 8'd9, 8'd0}; req = 4'hF;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk("b2b_gnt", 32'(gnt), 32'(1 << k));
            req[k] = 1'b0;
            @(negedge clk);
            chk_rsp("b2b_rsp", k, bin[k*8 +: 8]);
        end
        @(negedge clk);
        chk("b2b_idle", 32'(rsp_valid), 0);

        // Backpressure with a pending request
        reset1();
        bin[7:0] = 8'd50; req = 4'b0001;
        @(negedge clk);
        chk("bp_gnt0", 32'(gnt), 1);
        req = '0;
        @(negedge clk);
        rsp_ready = 1'b0; bin[15:8] = 8'd77; req[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk_rsp("bp_hold", 0, 8'd50);
            chk("bp_no_gnt", 32'(gnt), 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_gnt1", 32'(gnt), 2);
        chk("bp_valid_clr", 32'(rsp_valid), 0);
        req = '0;
        @(negedge clk);
        chk_rsp("bp_rsp1", 1, 8'd77);

        // Fairness between requesters 0 and 2 that keep requesting
        reset1();
        bin[7:0] = 8'd11; bin[23:16] = 8'd22; req = 4'b0101;
        for (int g = 0; g < 8; g++) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (gnt == '0 && t < 10);
            chk("fair_gnt", 32'(gnt), (g % 2 == 0) ? 1 : 4);
        end
        req = '0;
        repeat (4) @(negedge clk);

        // Converter check: bad digits for 58, then a correct conversion
        reset1();
        corrupt = 1'b1; bin[7:0] = 8'd58; req = 4'b0001;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        chk("chk_valid", 32'(rsp_valid), 1);
        chk("chk_tens_raw", 32'(rsp_dec[1]), 6);
        chk("chk_err_set", 32'(err), 32'(EXP_ERR));
        bin[7:0] = 8'd100; req = 4'b0001;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        chk_rsp("chk_rsp100", 0, 8'd100);
        chk("chk_err_sticky", 32'(err), 32'(EXP_ERR));
        rst_n = 1'b0;
        #1;
        chk("chk_err_reset", 32'(err), 0);
        reset1();

        // CONV_LAT = 3 latency, then reset during CONV
        @(negedge clk);
        rst2_n = 1'b1; bin2[7:0] = 8'd58; req2 = 4'b0001;
        @(negedge clk);
        chk("lat3_gnt", 32'(gnt2), 1);
        req2 = '0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("lat3_valid", 32'(rsp_valid2), (c == 3) ? 1 : 0);
        end
        chk("lat3_id", 32'(rsp_id2), 0);
        chk("lat3_d2", 32'(rsp_dec2[2]), 0);
        chk("lat3_d1", 32'(rsp_dec2[1]), 5);
        chk("lat3_d0", 32'(rsp_dec2[0]), 8);
        @(negedge clk);
        chk("lat3_valid_clr", 32'(rsp_valid2), 0);
        req2 = 4'b0001;
        @(negedge clk);
        chk("lat3_gnt2", 32'(gnt2), 1);
        req2 = '0;
        @(negedge clk);
        rst2_n = 1'b0;
        #1;
        chk("rstmid_conv_bin", 32'(conv_bin2), 0);
        chk("rstmid_valid", 32'(rsp_valid2), 0);
        chk("rstmid_id", 32'(rsp_id2), 0);
        chk("rstmid_dec", 32'({rsp_dec2[2], rsp_dec2[1], rsp_dec2[0]}), 0);
        @(negedge clk);
        rst2_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rstmid_no_rsp", 32'(rsp_valid2), 0);
        end

        // Randomized traffic against a round-robin reference model
        reset1();
        model_last = N - 1;
        for (int cyc = 0; cyc < 460; cyc++) begin
            @(negedge clk);
            if (gnt != '0) begin
                w = 0;
                found = 1'b0;
                for (int o = 1; o <= N; o++) begin
                    if (!found && req[(model_last + o) % N]) begin
                        w = (model_last + o) % N;
                        found = 1'b1;
                    end
                end
                chk("rnd_gnt", 32'(gnt), 32'(1 << w));
                q.push_back('{id: w, v: bin[w*8 +: 8]});
                model_last = w;
                chk("rnd_outstanding", q.size(), 1);
            end
            if (rsp_valid) begin
                chk("rnd_rsp_expected", 32'(q.size() != 0), 1);
                if (q.size() != 0) chk_rsp("rnd_rsp", q[0].id, q[0].v);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (rsp_valid && rsp_ready && q.size() != 0) void'(q.pop_front());
            for (int k = 0; k < N; k++) begin
                if (gnt[k]) begin
                    req[k] = 1'b0;
                end else if (!req[k] && cyc < 350 && $urandom_range(0, 3) == 0) begin
                    bin[k*8 +: 8] = 8'($urandom);
                    req[k] = 1'b1;
                end
            end
        end
        chk("rnd_drained", q.size(), 0);
        chk("rnd_req_done", 32'(req), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
